// File: rtl/iomem_pkg.sv
// iomem_pkg: shared state encoding, address-field constants and width helper for the iomem interconnect
package iomem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam int ID_W    = 8;
    localparam int ADDR_HI = 31;
    localparam int ADDR_LO = 24;
    localparam int DATA_W  = 32;

    // $clog2 that never yields a zero-width vector
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/iomem_addr_decode.sv
// iomem_addr_decode: priority match of the address top byte against the slave ID table
module iomem_addr_decode import iomem_pkg::*; #(
    parameter int                         NUM_SLAVES = 8,
    parameter logic [NUM_SLAVES*ID_W-1:0] SLAVE_IDS  = {8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01}
) (
    input  logic [DATA_W-1:0]                 i_addr,
    output logic                              o_hit,
    output logic [clog2_min1(NUM_SLAVES)-1:0] o_idx
);

    localparam int IDX_W = clog2_min1(NUM_SLAVES);

    // Scan from the top down so the lowest matching index is the one left standing
    always_comb begin
        o_hit = 1'b0;
        o_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (i_addr[ADDR_HI:ADDR_LO] == SLAVE_IDS[i*ID_W +: ID_W]) begin
                o_hit = 1'b1;
                o_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/iomem_interconnect.sv
// iomem_interconnect: decodes the picosoc iomem port onto N slaves with timeout watchdog and error reporting
module iomem_interconnect import iomem_pkg::*; #(
    parameter int                         NUM_SLAVES     = 8,
    parameter logic [NUM_SLAVES*ID_W-1:0] SLAVE_IDS      = {8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01},
    parameter int                         TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_W-1:0]          DEFAULT_RDATA  = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         m_valid,
    output logic                         m_ready,
    input  logic [DATA_W-1:0]            m_addr,
    output logic [DATA_W-1:0]            m_rdata,
    output logic [NUM_SLAVES-1:0]        s_valid,
    input  logic [NUM_SLAVES-1:0]        s_ready,
    input  logic [NUM_SLAVES*DATA_W-1:0] s_rdata,
    output logic                         err_timeout,
    output logic                         err_unmapped,
    output logic [15:0]                  err_count,
    output logic [DATA_W-1:0]            err_addr
);

    localparam int IDX_W = clog2_min1(NUM_SLAVES);
    localparam int CNT_W = clog2_min1(TIMEOUT_CYCLES + 1);

    state_t              r_state;
    state_t              w_next;
    logic [IDX_W-1:0]    r_sel;
    logic [CNT_W-1:0]    r_cnt;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_err_timeout;
    logic                r_err_unmapped;
    logic [15:0]         r_err_count;
    logic [DATA_W-1:0]   r_err_addr;
    logic                w_hit;
    logic [IDX_W-1:0]    w_idx;
    logic                w_sel_ready;
    logic [DATA_W-1:0]   w_sel_rdata;
    logic                w_expire;
    logic                w_unmapped_evt;
    logic                w_timeout_evt;

    iomem_addr_decode #(
        .NUM_SLAVES (NUM_SLAVES),
        .SLAVE_IDS  (SLAVE_IDS)
    ) u_decode (
        .i_addr (m_addr),
        .o_hit  (w_hit),
        .o_idx  (w_idx)
    );

    assign w_sel_ready    = s_ready[r_sel];
    assign w_sel_rdata    = s_rdata[r_sel*DATA_W +: DATA_W];
    assign w_expire       = (TIMEOUT_CYCLES != 0) && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign w_unmapped_evt = (r_state == IDLE) && m_valid && !w_hit;
    assign w_timeout_evt  = (r_state == ACTIVE) && m_valid && !w_sel_ready && w_expire;

    assign m_rdata      = r_rdata;
    assign err_timeout  = r_err_timeout;
    assign err_unmapped = r_err_unmapped;
    assign err_count    = r_err_count;
    assign err_addr     = r_err_addr;

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // Next state: a master abort takes priority, and slave ready beats a simultaneous expiry
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (m_valid) w_next = w_hit ? ACTIVE : RESP;
            ACTIVE:  if (!m_valid) w_next = IDLE;
                     else if (w_sel_ready || w_expire) w_next = RESP;
            default: w_next = IDLE;
        endcase
    end

    // Outputs decoded from the registered state, so s_valid appears the cycle after decode
    always_comb begin
        m_ready = (r_state == RESP);
        s_valid = (r_state == ACTIVE) ? (NUM_SLAVES'(1) << r_sel) : '0;
    end

    // Select latch, watchdog counter, response data and error bookkeeping
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_sel          <= '0;
            r_cnt          <= '0;
            r_rdata        <= '0;
            r_err_timeout  <= 1'b0;
            r_err_unmapped <= 1'b0;
            r_err_count    <= '0;
            r_err_addr     <= '0;
        end else begin
            r_err_timeout  <= w_timeout_evt;
            r_err_unmapped <= w_unmapped_evt;
            if (r_state == IDLE && m_valid) begin
                r_sel <= w_idx;
                r_cnt <= '0;
            end
            if (r_state == ACTIVE) r_cnt <= r_cnt + 1'b1;
            if (r_state == ACTIVE && m_valid && w_sel_ready) r_rdata <= w_sel_rdata;
            if (w_unmapped_evt || w_timeout_evt) begin
                r_rdata    <= DEFAULT_RDATA;
                r_err_addr <= m_addr;
                if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_iomem_interconnect.sv
// tb_iomem_interconnect: directed checks of decode, latency, timeout, unmapped, reset and abort behaviour
module tb_iomem_interconnect;

    logic         clk;
    logic         resetn;
    logic         m_valid;
    logic         m_ready;
    logic [31:0]  m_addr;
    logic [31:0]  m_rdata;
    logic [7:0]   s_valid;
    logic [7:0]   s_ready;
    logic [255:0] s_rdata;
    logic         err_timeout;
    logic         err_unmapped;
    logic [15:0]  err_count;
    logic [31:0]  err_addr;

    int n_cmp = 0;
    int n_err = 0;

    iomem_interconnect #(
        .NUM_SLAVES     (8),
        .SLAVE_IDS      ({8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h05, 8'h01}),
        .TIMEOUT_CYCLES (16),
        .DEFAULT_RDATA  (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .m_valid      (m_valid),
        .m_ready      (m_ready),
        .m_addr       (m_addr),
        .m_rdata      (m_rdata),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_rdata      (s_rdata),
        .err_timeout  (err_timeout),
        .err_unmapped (err_unmapped),
        .err_count    (err_count),
        .err_addr     (err_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        resetn  = 1'b0;
        m_valid = 1'b0;
        m_addr  = '0;
        s_ready = '0;
        s_rdata = '0;
        s_rdata[2*32 +: 32] = 32'hA5A5_1234;
        s_rdata[5*32 +: 32] = 32'h5555_0006;
        s_rdata[6*32 +: 32] = 32'h6666_0007;
        s_rdata[0*32 +: 32] = 32'h1111_0000;
        s_rdata[1*32 +: 32] = 32'h2222_0001;
        s_rdata[4*32 +: 32] = 32'h4444_0005;
        tick();
        tick();
        check("rst_m_ready", 32'(m_ready), 32'd0);
        check("rst_m_rdata", m_rdata, 32'h0);
        check("rst_s_valid", 32'(s_valid), 32'h0);
        check("rst_err_count", 32'(err_count), 32'd0);
        check("rst_err_addr", err_addr, 32'h0);
        resetn = 1'b1;
        tick();

        // mapped read, slave 2 ready on its first valid cycle
        m_valid = 1'b1;
        m_addr  = 32'h0300_0004;
        tick();
        check("rd_s_valid", 32'(s_valid), 32'h04);
        check("rd_no_ready_yet", 32'(m_ready), 32'd0);
        s_ready = 8'h04;
        tick();
        check("rd_m_ready", 32'(m_ready), 32'd1);
        check("rd_m_rdata", m_rdata, 32'hA5A5_1234);
        check("rd_s_valid_off", 32'(s_valid), 32'h0);
        check("rd_no_err", 32'({err_timeout, err_unmapped}), 32'd0);
        s_ready = '0;
        m_valid = 1'b0;
        tick();
        check("rd_ready_one_cycle", 32'(m_ready), 32'd0);
        check("rd_rdata_hold", m_rdata, 32'hA5A5_1234);

        // slow slave 5, ready on its 7th valid cycle
        m_valid = 1'b1;
        m_addr  = 32'h0600_0010;
        tick();
        for (int k = 1; k <= 7; k++) begin
            check($sformatf("slow_s_valid_%0d", k), 32'(s_valid), 32'h20);
            check($sformatf("slow_wait_%0d", k), 32'(m_ready), 32'd0);
            if (k == 7) s_ready = 8'h20;
            tick();
        end
        check("slow_m_ready", 32'(m_ready), 32'd1);
        check("slow_m_rdata", m_rdata, 32'h5555_0006);
        s_ready = '0;
        m_valid = 1'b0;
        tick();

        // unmapped access
        m_valid = 1'b1;
        m_addr  = 32'h7F00_0000;
        tick();
        check("unm_m_ready", 32'(m_ready), 32'd1);
        check("unm_m_rdata", m_rdata, 32'h0);
        check("unm_pulse", 32'(err_unmapped), 32'd1);
        check("unm_s_valid", 32'(s_valid), 32'h0);
        check("unm_err_addr", err_addr, 32'h7F00_0000);
        check("unm_err_count", 32'(err_count), 32'd1);
        m_valid = 1'b0;
        tick();
        check("unm_pulse_end", 32'(err_unmapped), 32'd0);

        // prime m_rdata with non-default data, then timeout on slave 6
        m_valid = 1'b1;
        m_addr  = 32'h0600_0000;
        tick();
        s_ready = 8'h20;
        tick();
        check("prime_rdata", m_rdata, 32'h5555_0006);
        s_ready = '0;
        m_valid = 1'b0;
        tick();
        m_valid = 1'b1;
        m_addr  = 32'h0700_0020;
        tick();
        for (int k = 1; k <= 15; k++) tick();
        check("to_still_active", 32'(s_valid), 32'h40);
        check("to_no_ready_yet", 32'(m_ready), 32'd0);
        tick();
        check("to_m_ready", 32'(m_ready), 32'd1);
        check("to_pulse", 32'(err_timeout), 32'd1);
        check("to_m_rdata", m_rdata, 32'h0);
        check("to_err_addr", err_addr, 32'h0700_0020);
        check("to_err_count", 32'(err_count), 32'd2);
        m_valid = 1'b0;
        tick();
        check("to_pulse_end", 32'(err_timeout), 32'd0);

        // ready in the expiry cycle wins
        m_valid = 1'b1;
        m_addr  = 32'h0700_0000;
        tick();
        for (int k = 1; k <= 15; k++) tick();
        s_ready = 8'h40;
        tick();
        check("tor_m_ready", 32'(m_ready), 32'd1);
        check("tor_no_pulse", 32'(err_timeout), 32'd0);
        check("tor_m_rdata", m_rdata, 32'h6666_0007);
        check("tor_err_count", 32'(err_count), 32'd2);
        s_ready = '0;
        m_valid = 1'b0;
        tick();

        // duplicate ID 0x05: slot 1 wins; unselected readies ignored; then reset mid-ACTIVE
        m_valid = 1'b1;
        m_addr  = 32'h0500_0000;
        tick();
        check("dup_s_valid", 32'(s_valid), 32'h02);
        s_ready = 8'h10;
        tick();
        check("ign_m_ready_a", 32'(m_ready), 32'd0);
        s_ready = 8'hFD;
        tick();
        check("ign_m_ready_b", 32'(m_ready), 32'd0);
        check("ign_s_valid", 32'(s_valid), 32'h02);
        resetn = 1'b0;
        tick();
        check("mrst_s_valid", 32'(s_valid), 32'h0);
        check("mrst_m_ready", 32'(m_ready), 32'd0);
        check("mrst_err_count", 32'(err_count), 32'd0);
        check("mrst_m_rdata", m_rdata, 32'h0);
        resetn  = 1'b1;
        s_ready = '0;
        m_valid = 1'b0;
        tick();
        m_valid = 1'b1;
        m_addr  = 32'h0100_0000;
        tick();
        check("post_s_valid", 32'(s_valid), 32'h01);
        s_ready = 8'h01;
        tick();
        check("post_m_ready", 32'(m_ready), 32'd1);
        check("post_m_rdata", m_rdata, 32'h1111_0000);
        s_ready = '0;
        m_valid = 1'b0;
        tick();

        // master abort returns to IDLE silently
        m_valid = 1'b1;
        m_addr  = 32'h0400_0000;
        tick();
        check("abt_s_valid", 32'(s_valid), 32'h08);
        m_valid = 1'b0;
        tick();
        check("abt_s_valid_off", 32'(s_valid), 32'h0);
        tick();
        check("abt_no_ready", 32'(m_ready), 32'd0);
        check("abt_err_count", 32'(err_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/iomem_interconnect.md
Name: iomem_interconnect

Overview:
Parametrised iomem bus interconnect between the picosoc iomem master port and N peripheral slaves.
- Replaces hand-written per-peripheral enable decode and ready/rdata muxing with a registered, table-driven decoder.
- Adds a per-transaction timeout watchdog, an unmapped-address default response and error status.
- Sits between the picosoc iomem port and all peripherals (gpio, audio, video, sdcard, i2c, flash).

Parameters:
NUM_SLAVES, 8, number of slave channels (1..16)
SLAVE_IDS, {8'h08,8'h07,8'h06,8'h05,8'h04,8'h03,8'h02,8'h01}, packed NUM_SLAVES*8 bits; slice i is the addr[31:24] match value for slave i
TIMEOUT_CYCLES, 1024, ACTIVE cycles before forced response; 0 disables the watchdog
DEFAULT_RDATA, 32'h0000_0000, rdata returned on unmapped or timed-out access

Ports:
clk  in  1  system clock
resetn  in  1  synchronous reset, active low
m_valid  in  1  master request valid (picosoc iomem_valid)
m_ready  out  1  one-cycle response strobe to master
m_addr  in  32  master address; also wired directly to all slaves
m_rdata  out  32  registered response data
s_valid  out  NUM_SLAVES  per-slave request valid, one-hot or zero
s_ready  in  NUM_SLAVES  per-slave ready
s_rdata  in  NUM_SLAVES*32  per-slave read data, slice i belongs to slave i
err_timeout  out  1  one-cycle pulse on watchdog expiry
err_unmapped  out  1  one-cycle pulse on unmapped access
err_count  out  16  saturating count of timeout plus unmapped events
err_addr  out  32  address of the most recent error
(Slaves receive m_wdata and m_wstrb directly at top level; they do not pass through this block.)

Behaviour:
- Reset (resetn low at posedge): state IDLE. m_ready=0, m_rdata=0, s_valid=0, err pulses=0, err_count=0, err_addr=0. Reset takes effect from any state, including mid-transaction; s_valid drops on that same edge.
- FSM: IDLE, ACTIVE, RESP.
- IDLE, m_valid=1:
  - Decode m_addr[31:24] against SLAVE_IDS. Lowest matching index wins on duplicates.
  - Match: latch sel and go to ACTIVE. s_valid[sel]=1 from the next cycle (registered).
  - No match: go to RESP with m_rdata=DEFAULT_RDATA. Pulse err_unmapped, set err_addr=m_addr, increment err_count.
- ACTIVE:
  - s_valid[sel] held at 1; timeout counter increments each cycle.
  - s_ready[sel]=1: capture s_rdata slice sel into m_rdata and go to RESP. Ready from non-selected slaves is ignored.
  - Counter reaches TIMEOUT_CYCLES-1 with no ready: go to RESP with DEFAULT_RDATA. Pulse err_timeout, set err_addr, increment err_count. If ready and expiry occur in the same cycle, ready wins and no error is raised.
  - m_valid drops (master abort): return to IDLE with no response, s_valid cleared, no error.
- RESP: m_ready=1 for exactly one cycle, s_valid=0, then IDLE. m_rdata holds its value until the next capture.
- Latency: a slave ready on its first valid cycle gives m_ready 2 cycles after the IDLE sample of m_valid. An unmapped access gives m_ready 1 cycle after it.
- The master must drop m_valid in the cycle after m_ready (picorv32 behaviour). IDLE does not re-decode in the RESP cycle.
- err_count saturates at 16'hFFFF.
- Timeout counter width is clog2(TIMEOUT_CYCLES+1) and clears on every entry to ACTIVE.

Decomposition:
- Shared package iomem_pkg:
  - state encoding (IDLE=2'd0, ACTIVE=2'd1, RESP=2'd2)
  - ID_W=8, ADDR_HI=31, ADDR_LO=24
  - DATA_W=32
- One sub-module, iomem_addr_decode: combinational priority match of m_addr[31:24] against SLAVE_IDS. Outputs hit (1) and idx (clog2(NUM_SLAVES)).

Test Plan:
- Mapped read: m_addr=0x0300_0004, slave 2 (ID 0x03) ready on its 1st valid cycle with rdata 0xA5A5_1234 -> s_valid=3'b100 pattern for one cycle, m_ready 2 cycles after request, m_rdata=0xA5A5_1234, no error pulse.
- Slow slave: slave 5 ready after 7 cycles -> s_valid[5] high for 7 cycles, m_ready on the 8th cycle after request start, m_rdata correct.
- Unmapped: m_addr=0x7F00_0000 -> m_ready 1 cycle later, m_rdata=0, err_unmapped pulse, err_addr=0x7F00_0000, err_count=1.
- Timeout: TIMEOUT_CYCLES=16, slave never ready -> m_ready after 16 ACTIVE cycles, err_timeout pulse, m_rdata=DEFAULT_RDATA. Repeat with ready in the expiry cycle -> no error.
- Reset mid-ACTIVE: resetn low while s_valid[1]=1 -> next edge s_valid=0, m_ready=0, err_count=0, state IDLE; the next access completes normally.
- Duplicate IDs (slices 1 and 4 both 0x05) -> only s_valid[1] asserts. Unselected slave ready toggling during ACTIVE is ignored.
